// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, reads the word-addressed instruction
// memory and buffers returned words in an in-order queue drained by decode.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          IMEM_WORDS = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [31:0]                   imem_pc,
    input  logic [31:0]                   imem_instruction,
    input  logic                          redirect_valid,
    input  logic [31:0]                   redirect_pc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_instruction,
    output logic [31:0]                   out_pc,
    output logic [$clog2(FIFO_DEPTH):0]   out_count,
    output logic                          fetch_fault
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [31:0]   r_fetch_pc;
    logic          r_fault;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_q_pc  [FIFO_DEPTH];
    logic [31:0]   r_q_ins [FIFO_DEPTH];

    logic w_aligned;
    logic w_in_range;
    logic w_fetch_ok;
    logic w_valid;
    logic w_pop;
    logic w_push;

    assign w_aligned  = (r_fetch_pc[1:0] == 2'b00);
    assign w_in_range = ({2'b00, r_fetch_pc[31:2]} < 32'(IMEM_WORDS));
    assign w_fetch_ok = !r_fault && w_aligned && w_in_range;
    assign w_valid    = (r_count != '0);

    // Handshake: a head entry transfers on a cycle where out_valid and out_ready
    // are both high; a redirect in that cycle discards the head instead.
    assign w_pop  = w_valid && out_ready && !redirect_valid;
    assign w_push = w_fetch_ok && !redirect_valid && ((r_count < DEPTH_C) || w_pop);

    assign imem_pc         = r_fetch_pc;
    assign out_valid       = w_valid;
    assign out_pc          = w_valid ? r_q_pc[r_rd_ptr]  : 32'h0;
    assign out_instruction = w_valid ? r_q_ins[r_rd_ptr] : 32'h0;
    assign out_count       = r_count;
    assign fetch_fault     = r_fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_fault    <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
            r_fault    <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            // Sticky until redirect or reset; fetch_pc freezes via w_fetch_ok.
            if (!w_aligned || !w_in_range) begin
                r_fault <= 1'b1;
            end
        end
    end

    // Storage needs no reset: emptiness is tracked by r_count and masks the head view.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_q_pc[r_wr_ptr]  <= r_fetch_pc;
            r_q_ins[r_wr_ptr] <= imem_instruction;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a behavioural instruction memory and a
// scoreboard of expected {pc, word} pairs consumed on each decode handshake.
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] imem_pc;
    logic [31:0] imem_instruction;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic [2:0]  out_count;
    logic        fetch_fault;

    logic [31:0] tb_mem [64];
    logic [63:0] exp_q [$];
    int n_tests;
    int n_fail;

    inst_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4),
        .IMEM_WORDS (64)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_pc          (imem_pc),
        .imem_instruction (imem_instruction),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instruction  (out_instruction),
        .out_pc           (out_pc),
        .out_count        (out_count),
        .fetch_fault      (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_instruction = (imem_pc[31:8] == 24'h0) ? tb_mem[imem_pc[7:2]] : 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic exp_run(input logic [31:0] start_pc, input int n);
        logic [31:0] pc;
        for (int k = 0; k < n; k++) begin
            pc = start_pc + 32'(4 * k);
            exp_q.push_back({pc, tb_mem[pc[7:2]]});
        end
    endtask

    // One clock: score a handshake at the negedge, then return just after the posedge.
    task automatic cycle();
        logic [63:0] e;
        @(negedge clk);
        if (out_valid && out_ready && !redirect_valid && !rst) begin
            n_tests++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_extra: got pc %h expected no output", out_pc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_pc", out_pc, e[63:32]);
                check("sb_ins", out_instruction, e[31:0]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_count"}, 32'(out_count), 32'd0);
        check({tag, "_fault"}, 32'(fetch_fault), 32'd0);
        check({tag, "_pc"}, out_pc, 32'd0);
        check({tag, "_ins"}, out_instruction, 32'd0);
        check({tag, "_imem_pc"}, imem_pc, 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 64; i++) tb_mem[i] = 32'hA500_0000 + 32'(i) * 32'h0001_0001;
        tb_mem[0] = 32'hfe010113;
        tb_mem[1] = 32'h00812e23;
        tb_mem[2] = 32'h02010413;
        tb_mem[3] = 32'hfea42623;
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        out_ready = 1'b1;

        // Reset, then sustained fetch with decode always ready.
        cycles(2);
        check_reset_state("reset");
        rst = 1'b0;
        exp_run(32'h0, 4);
        cycle();
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_pc", out_pc, 32'h0);
        cycles(4);
        check("stream_drained", 32'(exp_q.size()), 32'd0);

        // Back-pressure: queue fills to 4 and fetch stalls at 16.
        rst = 1'b1;
        out_ready = 1'b0;
        cycle();
        rst = 1'b0;
        cycles(10);
        check("full_count", 32'(out_count), 32'd4);
        check("full_imem_pc", imem_pc, 32'h10);
        check("full_head_pc", out_pc, 32'h0);
        check("full_head_ins", out_instruction, tb_mem[0]);
        exp_run(32'h0, 8);
        out_ready = 1'b1;
        cycle();
        check("full_pop_count", 32'(out_count), 32'd4);
        check("full_pop_imem_pc", imem_pc, 32'h14);
        cycles(7);
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Redirect with three entries queued and decode ready.
        rst = 1'b1;
        out_ready = 1'b0;
        cycle();
        rst = 1'b0;
        cycles(3);
        check("pre_redir_count", 32'(out_count), 32'd3);
        redirect_valid = 1'b1;
        redirect_pc = 32'h34;
        out_ready = 1'b1;
        cycle();
        redirect_valid = 1'b0;
        exp_q.delete();
        check("redir_valid", 32'(out_valid), 32'd0);
        check("redir_count", 32'(out_count), 32'd0);
        check("redir_imem_pc", imem_pc, 32'h34);
        exp_run(32'h34, 3);
        cycle();
        check("redir_head_pc", out_pc, 32'h34);
        check("redir_head_ins", out_instruction, tb_mem[13]);
        cycles(3);
        check("redir_drained", 32'(exp_q.size()), 32'd0);

        // Run off the end of memory with decode stalled, then drain under fault.
        out_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'hF0;
        cycle();
        redirect_valid = 1'b0;
        exp_q.delete();
        cycles(4);
        check("end_count", 32'(out_count), 32'd4);
        check("end_fault_pre", 32'(fetch_fault), 32'd0);
        check("end_imem_pc", imem_pc, 32'h100);
        cycle();
        check("end_fault", 32'(fetch_fault), 32'd1);
        cycles(2);
        check("fault_hold_count", 32'(out_count), 32'd4);
        check("fault_hold_pc", imem_pc, 32'h100);
        exp_run(32'hF0, 4);
        out_ready = 1'b1;
        cycles(4);
        check("fault_drain_count", 32'(out_count), 32'd0);
        check("fault_drain_valid", 32'(out_valid), 32'd0);
        check("fault_drain_pc", out_pc, 32'h0);
        check("fault_still_set", 32'(fetch_fault), 32'd1);
        check("fault_drained", 32'(exp_q.size()), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        cycle();
        redirect_valid = 1'b0;
        check("fault_clear", 32'(fetch_fault), 32'd0);
        check("fault_clear_pc", imem_pc, 32'h0);
        exp_run(32'h0, 3);
        cycles(4);
        check("resume_drained", 32'(exp_q.size()), 32'd0);

        // Misaligned redirect target faults on the following edge.
        redirect_valid = 1'b1;
        redirect_pc = 32'h6;
        cycle();
        redirect_valid = 1'b0;
        exp_q.delete();
        check("mis_fault_pre", 32'(fetch_fault), 32'd0);
        check("mis_count_pre", 32'(out_count), 32'd0);
        cycle();
        check("mis_fault", 32'(fetch_fault), 32'd1);
        cycles(2);
        check("mis_count", 32'(out_count), 32'd0);
        check("mis_imem_pc", imem_pc, 32'h6);

        // Reset wins over a simultaneous redirect.
        rst = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        cycle();
        check_reset_state("rst_redir");
        rst = 1'b0;
        redirect_valid = 1'b0;
        cycle();
        check("post_rst_head", out_pc, 32'h0);
        check("post_rst_ins", out_instruction, tb_mem[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
